// File: rtl/rr_requester_frontend.sv
// Requester front end for a round-robin bus arbiter.
// Four ports each queue burst jobs; the arbiter's registered one-hot grant
// drains beats from the granted port. Grant anomalies are flagged.

// Per-port job queue, occupancy and head-job beat countdown.
module rr_port #(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_valid,
  input  logic [1:0] push_len,
  input  logic       beat,
  output logic       ready,
  output logic       req,
  output logic       last,
  output logic       pop,
  output logic       done
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [1:0]    mem_q [QDEPTH];
  logic [1:0]    mem_d [QDEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [AW:0]   occ_q, occ_d;
  logic [1:0]    rem_q, rem_d;
  logic          done_q;
  logic          push;

  // ready/req come straight from the occupancy register so they never glitch
  assign ready  = (occ_q != (AW+1)'(QDEPTH));
  assign req    = (occ_q != '0);
  assign last   = (rem_q == 2'd0);
  assign push   = push_valid && ready;
  assign pop    = beat && last;
  assign rd_nxt = rd_q + AW'(1);
  assign done   = done_q;

  // Next-state for queue storage, pointers, occupancy and head countdown
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    rem_d = rem_q;
    if (push) begin
      mem_d[wr_q] = push_len;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_nxt;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    // The next head loads on the popping edge so a held grant runs gap-free.
    // With one entry left plus a same-cycle push, the pushed job is the new head.
    if (pop) begin
      if (occ_q > (AW+1)'(1)) rem_d = mem_q[rd_nxt];
      else if (push)          rem_d = push_len;
      else                    rem_d = 2'd0;
    end else if (beat) begin
      rem_d = rem_q - 2'd1;
    end else if (push && (occ_q == '0)) begin
      rem_d = push_len;
    end
  end

  // State registers; reset drops every queued and partial job silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= 2'd0;
      wr_q   <= '0;
      rd_q   <= '0;
      occ_q  <= '0;
      rem_q  <= 2'd0;
      done_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
      rem_q  <= rem_d;
      done_q <= pop;
    end
  end
endmodule

module rr_requester_frontend #(
  parameter int QDEPTH = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       job_valid,
  input  logic [7:0]       job_len,
  output logic [3:0]       job_ready,
  output logic [3:0]       REQ,
  input  logic [3:0]       GNT,
  output logic             beat_valid,
  output logic [1:0]       beat_port,
  output logic             beat_last,
  output logic [3:0]       done,
  output logic             stale_gnt,
  output logic             err_multi,
  output logic [CNT_W-1:0] jobs_done
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] beat_vec, last_vec, pop_vec;
  logic                 gnt_multi, gnt_one;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     jobs_done_q, jobs_done_d;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_port
      rr_port #(.QDEPTH(QDEPTH)) u_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (job_valid[g]),
        .push_len   (job_len[2*g+1:2*g]),
        .beat       (beat_vec[g]),
        .ready      (job_ready[g]),
        .req        (REQ[g]),
        .last       (last_vec[g]),
        .pop        (pop_vec[g]),
        .done       (done[g])
      );
    end
  endgenerate

  // Grant decode: only a one-hot grant to a requesting port issues a beat
  always_comb begin
    gnt_multi  = ((GNT & (GNT - 4'd1)) != 4'd0);
    gnt_one    = (GNT != 4'd0) && !gnt_multi;
    beat_vec   = gnt_one ? (GNT & REQ) : 4'd0;
    beat_valid = (beat_vec != 4'd0);
    beat_last  = ((beat_vec & last_vec) != 4'd0);
    stale_gnt  = gnt_one && ((GNT & REQ) == 4'd0);
    beat_port  = 2'd0;
    for (int i = 0; i < NUM_LANES; i++)
      if (beat_vec[i]) beat_port = 2'(i);
    err_d       = err_q | gnt_multi;
    // At most one port pops per cycle, so one increment covers it
    jobs_done_d = jobs_done_q + CNT_W'(pop_vec != 4'd0);
  end

  // Sticky multi-grant error and completed-job counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      err_q       <= err_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  assign err_multi = err_q;
  assign jobs_done = jobs_done_q;
endmodule

// File: doc/rr_requester_frontend.md
RR_REQUESTER_FRONTEND -- requirements
Module: rr_requester_frontend

Interface
REQ-001 Parameter QDEPTH, default 2, jobs held per port; power of 2, at least 2.
REQ-002 Parameter CNT_W, default 8, width of the completed-job counter.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Asynchronous, active-low reset.
REQ-005 job_valid  input  4  Per-port job push strobe.
REQ-006 job_len  input  8  Per-port burst length minus 1; port i uses bits [2i+1:2i]; 0 means 1 beat, 3 means 4 beats.
REQ-007 job_ready  output  4  Per-port queue not full.
REQ-008 REQ  output  4  Bus request to the round-robin arbiter, one bit per port.
REQ-009 GNT  input  4  Registered grant from the arbiter; one-hot or zero expected.
REQ-010 beat_valid  output  1  A data beat is issued this cycle.
REQ-011 beat_port  output  2  Port index of the issued beat.
REQ-012 beat_last  output  1  Issued beat is the final beat of its job.
REQ-013 done  output  4  One-cycle pulse per port on job completion.
REQ-014 stale_gnt  output  1  One-cycle pulse on a grant to a port not requesting.
REQ-015 err_multi  output  1  Sticky flag: GNT had more than one bit set.
REQ-016 jobs_done  output  CNT_W  Count of completed jobs, wraps modulo 2^CNT_W.

Function
REQ-017 Each port SHALL hold a FIFO of QDEPTH job lengths plus a registered occupancy count and a 2-bit remaining-beat counter for the head job.
REQ-018 job_ready[i] SHALL equal (occupancy_i != QDEPTH), driven from registers only.
REQ-019 A push SHALL occur when job_valid[i] and job_ready[i] are both 1; job_valid while not ready SHALL be dropped with no state change.
REQ-020 REQ[i] SHALL equal (occupancy_i != 0), driven from registers only, so REQ never glitches.
REQ-021 A beat SHALL be issued combinationally in a cycle where GNT is one-hot with bit i set and REQ[i]=1: beat_valid=1 and beat_port=i.
REQ-022 When no beat is issued, beat_valid SHALL be 0, and beat_port and beat_last SHALL be 0.
REQ-023 When the head job becomes head, its remaining counter SHALL load job_len; each issued beat SHALL decrement it by 1.
REQ-024 beat_last SHALL be 1 when the remaining counter equals 0 at the issued beat; that beat SHALL pop the head job on the same edge.
REQ-025 After a pop, the next head, if any, SHALL load its length on the same edge, so back-to-back jobs under a continuous grant incur no idle cycle.
REQ-026 Simultaneous push and pop on one port SHALL keep occupancy unchanged.
REQ-027 A push into an empty port SHALL load the remaining counter directly from job_len.
REQ-028 done[i] SHALL pulse high one cycle after the beat_last beat of port i; jobs_done SHALL increment on that same cycle.
REQ-029 A GNT that is one-hot with bit i set while REQ[i]=0 SHALL be ignored and SHALL raise stale_gnt for that cycle; this covers the arbiter's one-cycle grant lag after REQ drops.
REQ-030 If GNT has two or more bits set, no beat SHALL be issued, err_multi SHALL set and remain set until reset, and stale_gnt SHALL stay 0.
REQ-031 GNT=0 SHALL cause no beat and no flag.
REQ-032 A grant held for several cycles SHALL issue one beat per cycle while REQ[i]=1, including across job boundaries within the same port.
REQ-033 A port that loses its grant mid-job SHALL keep its remaining count and resume on its next grant.

Reset
REQ-034 While rst_n=0, all queues SHALL be emptied and all remaining counters cleared; REQ=0, job_ready=4'b1111, beat_valid=0, done=0, stale_gnt=0, err_multi=0 and jobs_done=0.
REQ-035 Reset asserted mid-burst SHALL discard all queued and partial jobs without any done pulse.
REQ-036 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Verification
REQ-037 Push a port-0 job with len=2, then GNT=0001 for 3 cycles -> 3 beats on port 0, beat_last on the 3rd beat, done=0001 the next cycle, REQ[0] falls, jobs_done=1.
REQ-038 Push two port-2 jobs (len 0, len 1) with GNT=0100 held -> 3 consecutive beats with beat_last on beats 1 and 3, and two done pulses.
REQ-039 Fill port 1 with QDEPTH jobs -> job_ready[1]=0; a further push is dropped; pop one job -> job_ready[1] returns to 1.
REQ-040 Port 3 has len=3; GNT=1000 for 2 cycles, 0001 for 1 cycle, then 1000 -> port 3 resumes, beat_last on its 4th total beat.
REQ-041 GNT=0010 while REQ[1]=0 -> stale_gnt pulses and no beat; GNT=0110 -> err_multi=1 and stays 1 until rst_n=0.
REQ-042 Assert rst_n=0 during the second beat of a len=3 job -> all outputs return to their reset values and no done pulse occurs.
